// File: rtl/udiv_24x12.sv
// udiv_24x12 -- sequential unsigned restoring divider, NN-bit dividend by
// ND-bit divisor, one quotient bit per clock, NN clocks of latency.
//
// Ports
//   i_clk, i_reset_n     clock (rising edge) / asynchronous active-low reset
//   i_stb                request, accepted when o_busy=0
//   i_num, i_den, i_aux  dividend, divisor, tag (captured on accept)
//   o_busy               division in progress
//   o_valid              one-cycle result strobe
//   o_quot, o_rem        quotient / remainder, held until the next result
//   o_err                divide-by-zero flag (only with the macro below)
//   o_aux                tag captured with the request
//
// Build option
//   UDIV_ZERO_CHECK_EN   a zero divisor short-circuits: the result (err=1,
//                        quot all ones, rem 0) appears one clock after accept.
//                        Undefined: o_err is 0 and a zero divisor runs the
//                        full NN steps (quot all ones, rem = low dividend bits).
module udiv_24x12 #(
  parameter int NN = 24,
  parameter int ND = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_stb,
  input  logic [NN-1:0] i_num,
  input  logic [ND-1:0] i_den,
  input  logic          i_aux,
  output logic          o_busy,
  output logic          o_valid,
  output logic [NN-1:0] o_quot,
  output logic [ND-1:0] o_rem,
  output logic          o_err,
  output logic          o_aux
);

  localparam int CW = $clog2(NN + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NN-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [ND-1:0] r_q, r_d;        // partial remainder
  logic [ND-1:0] d_q, d_d;        // latched divisor
  logic          tag_q, tag_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [NN-1:0] quot_q, quot_d;
  logic [ND-1:0] rem_q, rem_d;
  logic          aux_q, aux_d;
`ifdef UDIV_ZERO_CHECK_EN
  logic          zpend_q, zpend_d;  // zero-divisor result due next edge
  logic          err_q, err_d;
`endif

  logic [ND:0]   t;
  logic          borrow;
  logic [ND-1:0] r_step;
  logic [NN-1:0] q_step;
  logic          accept;

  assign accept = i_stb & ~busy_q;

  always_comb begin
    // One restoring step. The subtract is judged by a true borrow (t < d)
    // rather than the top bit of an ND+1-bit difference: the two agree for
    // any non-zero divisor, and the borrow form keeps a zero divisor from
    // ever producing a 0 quotient bit (quotient all ones).
    t      = {r_q, q_q[NN-1]};
    borrow = (t < {1'b0, d_q});
    r_step = borrow ? t[ND-1:0] : (t[ND-1:0] - d_q);
    q_step = {q_q[NN-2:0], ~borrow};

    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    aux_d   = aux_q;
`ifdef UDIV_ZERO_CHECK_EN
    zpend_d = 1'b0;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef UDIV_ZERO_CHECK_EN
        if (zpend_q) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          quot_d  = '1;
          rem_d   = '0;
          aux_d   = tag_q;
        end
`endif
        if (accept) begin
          q_d   = i_num;
          r_d   = '0;
          d_d   = i_den;
          tag_d = i_aux;
          busy_d = 1'b1;
`ifdef UDIV_ZERO_CHECK_EN
          if (i_den == '0) begin
            zpend_d = 1'b1;
          end else begin
            cnt_d   = CW'(NN);
            state_d = S_RUN;
          end
`else
          cnt_d   = CW'(NN);
          state_d = S_RUN;
`endif
        end
      end
      default: begin  // S_RUN
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quot_d  = q_step;
          rem_d   = r_step;
          aux_d   = tag_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef UDIV_ZERO_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      tag_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      aux_q   <= 1'b0;
`ifdef UDIV_ZERO_CHECK_EN
      zpend_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      aux_q   <= aux_d;
`ifdef UDIV_ZERO_CHECK_EN
      zpend_q <= zpend_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_quot  = quot_q;
  assign o_rem   = rem_q;
  assign o_aux   = aux_q;
`ifdef UDIV_ZERO_CHECK_EN
  assign o_err   = err_q;
`else
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_udiv_24x12.sv
// Self-checking bench for udiv_24x12: directed cases plus randomized
// operands checked against plain integer / and % from a reference function.
module tb_udiv_24x12;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_stb = 1'b0;
  logic [23:0] i_num = '0;
  logic [11:0] i_den = '0;
  logic        i_aux = 1'b0;
  logic        o_busy, o_valid, o_err, o_aux;
  logic [23:0] o_quot;
  logic [11:0] o_rem;

  int checks = 0;
  int errors = 0;

  udiv_24x12 dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_stb), .i_num(i_num),
    .i_den(i_den), .i_aux(i_aux), .o_busy(o_busy), .o_valid(o_valid),
    .o_quot(o_quot), .o_rem(o_rem), .o_err(o_err), .o_aux(o_aux)
  );

  always #5 i_clk = ~i_clk;

  // Reference: integer division; zero divisor per the build option.
  function automatic void model(input logic [23:0] n, input logic [11:0] d,
                                output logic [23:0] eq, output logic [11:0] er,
                                output int elat, output logic eerr);
    if (d == 0) begin
      eq = 24'hFFFFFF;
`ifdef UDIV_ZERO_CHECK_EN
      er = 12'h0; elat = 1; eerr = 1'b1;
`else
      er = n[11:0]; elat = 24; eerr = 1'b0;
`endif
    end else begin
      eq = n / {12'h0, d};
      er = 12'(n % {12'h0, d});
      elat = 24; eerr = 1'b0;
    end
  endfunction

  // Stimulus only: present one request, wait (bounded) for o_valid.
  // Entered and left at #1 after a rising edge. lat = edges after accept.
  task automatic run_op(input logic [23:0] n, input logic [11:0] d, input logic a,
                        output int lat, output int busy_bad);
    i_num = n; i_den = d; i_aux = a; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    lat = -1; busy_bad = 0;
    if (!o_busy) busy_bad++;
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin lat = k; break; end
      if (!o_busy) busy_bad++;
    end
  endtask

  task automatic test_basic;
    int lat, bb;
    run_op(24'd1000, 12'd7, 1'b1, lat, bb);
    checks++; if (lat !== 24) begin errors++; $display("FAIL basic_latency got %0d exp 24", lat); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy low_cycles %0d exp 0", bb); end
    checks++; if (o_quot !== 24'd142) begin errors++; $display("FAIL basic_quot got %0d exp 142", o_quot); end
    checks++; if (o_rem !== 12'd6) begin errors++; $display("FAIL basic_rem got %0d exp 6", o_rem); end
    checks++; if (o_aux !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL basic_aux_err got %b%b exp 10", o_aux, o_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", o_busy); end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", o_valid); end
    checks++; if (o_quot !== 24'd142 || o_rem !== 12'd6) begin errors++; $display("FAIL basic_hold got %0d/%0d exp 142/6", o_quot, o_rem); end
  endtask

  task automatic test_reset;
    // Outputs are non-zero from the previous test; reset mid-cycle.
    #3 i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_valid, o_err, o_aux} !== 4'b0 || o_quot !== 24'h0 || o_rem !== 12'h0) begin
      errors++;
      $display("FAIL reset_async got busy%b valid%b err%b aux%b q%h r%h exp all 0",
               o_busy, o_valid, o_err, o_aux, o_quot, o_rem);
    end
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
  endtask

  task automatic test_extremes;
    logic [23:0] tn[3] = '{24'hFFFFFF, 24'hFFFFFF, 24'd5};
    logic [11:0] td[3] = '{12'd1, 12'hFFF, 12'hFFF};
    logic [23:0] tq[3] = '{24'hFFFFFF, 24'h001001, 24'd0};
    logic [11:0] tr[3] = '{12'd0, 12'd0, 12'd5};
    int lat, bb;
    for (int i = 0; i < 3; i++) begin
      run_op(tn[i], td[i], i[0], lat, bb);
      checks++;
      if (lat !== 24 || o_quot !== tq[i] || o_rem !== tr[i] || o_aux !== i[0]) begin
        errors++;
        $display("FAIL extreme_%0d got lat%0d q%h r%h aux%b exp lat24 q%h r%h aux%b",
                 i, lat, o_quot, o_rem, o_aux, tq[i], tr[i], i[0]);
      end
    end
  endtask

  task automatic test_random;
    logic [23:0] n, eq;
    logic [11:0] d, er;
    logic a, eerr;
    int lat, bb, elat;
    for (int i = 0; i < 40; i++) begin
      n = 24'($urandom);
      case (i % 4)
        0: d = 12'($urandom_range(1, 15));
        1: d = 12'($urandom_range(3000, 4095));
        default: d = 12'($urandom);
      endcase
      a = 1'($urandom);
      model(n, d, eq, er, elat, eerr);
      run_op(n, d, a, lat, bb);
      checks++;
      if (lat !== elat || bb !== 0 || o_quot !== eq || o_rem !== er || o_aux !== a || o_err !== eerr) begin
        errors++;
        $display("FAIL random_%0d %h/%h got lat%0d bb%0d q%h r%h aux%b err%b exp lat%0d q%h r%h aux%b err%b",
                 i, n, d, lat, bb, o_quot, o_rem, o_aux, o_err, elat, eq, er, a, eerr);
      end
    end
  endtask

  // i_stb held high with churning operands, then a back-to-back request
  // presented on the o_valid cycle.
  task automatic test_back_to_back;
    int lat;
    logic seen;
    i_num = 24'd1000; i_den = 12'd7; i_aux = 1'b0; i_stb = 1'b1;
    @(posedge i_clk); #1;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      i_num = 24'($urandom); i_den = 12'($urandom); i_aux = 1'($urandom);
      @(posedge i_clk); #1;
      if (o_valid) begin
        seen = 1'b1;
        checks++;
        if (k !== 24 || o_quot !== 24'd142 || o_rem !== 12'd6 || o_aux !== 1'b0) begin
          errors++;
          $display("FAIL hold_stb got lat%0d q%0d r%0d aux%b exp lat24 q142 r6 aux0", k, o_quot, o_rem, o_aux);
        end
      end
    end
    if (!seen) begin checks++; errors++; $display("FAIL hold_stb got no o_valid exp valid at 24"); end
    i_num = 24'd5000; i_den = 12'd13; i_aux = 1'b1;   // accepted on the valid-cycle edge
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 24 || o_quot !== 24'd384 || o_rem !== 12'd8 || o_aux !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back got lat%0d q%0d r%0d aux%b exp lat24 q384 r8 aux1", lat, o_quot, o_rem, o_aux);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bb, vcount;
    i_num = 24'd1000; i_den = 12'd7; i_aux = 1'b1; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    repeat (10) @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b exp 0", o_busy); end
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid) vcount++;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL reset_mid_novalid got %0d pulses exp 0", vcount); end
    run_op(24'd100, 12'd9, 1'b0, lat, bb);
    checks++;
    if (lat !== 24 || o_quot !== 24'd11 || o_rem !== 12'd1) begin
      errors++;
      $display("FAIL reset_mid_after got lat%0d q%0d r%0d exp lat24 q11 r1", lat, o_quot, o_rem);
    end
  endtask

  task automatic test_div_zero;
    int lat, bb;
    logic [23:0] eq;
    logic [11:0] er;
    logic eerr;
    int elat;
    model(24'h123456, 12'h0, eq, er, elat, eerr);
    run_op(24'h123456, 12'h0, 1'b1, lat, bb);
    checks++;
    if (lat !== elat || o_quot !== eq || o_rem !== er || o_err !== eerr || o_aux !== 1'b1) begin
      errors++;
      $display("FAIL div_zero got lat%0d q%h r%h err%b aux%b exp lat%0d q%h r%h err%b aux1",
               lat, o_quot, o_rem, o_err, o_aux, elat, eq, er, eerr);
    end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL div_zero_pulse got %b exp 0", o_valid); end
  endtask

  initial begin
    #1 i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    test_basic();
    test_reset();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
